// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams a range of 32-bit words out of a synchronous
// memory into a two-entry output buffer with a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; no reads issued
// RUN    | issuing reads and delivering words until count handshakes
// FINISH | one-cycle completion, done asserted, busy low
module mem_dump_reader #(
  parameter int AW         = 14,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  input  logic          mem_init_busy,
  output logic [AW+1:0] mem_address,
  output logic          mem_wren,
  input  logic [31:0]   mem_q,
  output logic [31:0]   out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0]    DEPTH_C = 3'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  state_t        state_q, state_d;
  logic          start_ok;

  logic [AW-1:0] ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   issued_q;
  logic [AW:0]   popped_q;
  logic          inflight_q;
  logic [AW-1:0] inflight_addr_q;

  logic [31:0]   fifo_data_q [2];
  logic [AW-1:0] fifo_addr_q [2];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    fifo_cnt_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic          last_pop;
  logic [2:0]    occ_after;

  // A word leaves the buffer on handshake and enters it one cycle after its read.
  assign pop  = out_valid & out_ready;
  assign push = inflight_q;

  // Occupancy counted as if this cycle's pop already happened, so a read may be
  // issued into the slot being freed and full throughput is kept.
  assign occ_after = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && !mem_init_busy &&
                     (issued_q < count_q) && (occ_after < DEPTH_C);
  assign last_pop  = (state_q == RUN) && pop && ((popped_q + CNT_ONE) == count_q);

  // State register.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (word_count == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_pop) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read pointer, progress counters and the tag of the read in flight.
  always_ff @(posedge clock) begin
    if (!rst) begin
      ptr_q           <= '0;
      count_q         <= '0;
      issued_q        <= '0;
      popped_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      if (start_ok) begin
        ptr_q    <= base_addr;
        count_q  <= word_count;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) begin
          ptr_q    <= ptr_q + PTR_ONE;
          issued_q <= issued_q + CNT_ONE;
        end
        if (pop) begin
          popped_q <= popped_q + CNT_ONE;
        end
      end
      inflight_q <= issue;
      if (issue) begin
        inflight_addr_q <= ptr_q;
      end
    end
  end

  // Output buffer pointers and fill level; push and pop together keep the level.
  always_ff @(posedge clock) begin
    if (!rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Output buffer storage; contents are don't-care while the level is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_q;
      fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

  assign mem_address = {ptr_q, 2'b00};
  assign mem_wren    = 1'b0;
  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_addr    = fifo_addr_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dump scenarios plus reset sequences.
module tb_mem_dump_reader;
  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          mem_init_busy;
  logic [AW+1:0] mem_address;
  logic          mem_wren;
  logic [31:0]   mem_q;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [13:0] base;
    logic [14:0] cnt;
    int          rmode;
    int          bmode;
    bit          restart;
    logic [13:0] exp_last;
  } vec_t;

  vec_t vecs [8];

  mem_dump_reader #(.AW(AW), .FIFO_DEPTH(2)) dut (
    .clock         (clock),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .mem_init_busy (mem_init_busy),
    .mem_address   (mem_address),
    .mem_wren      (mem_wren),
    .mem_q         (mem_q),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  // Memory model: word i holds 0xA5000000 + i, one cycle read latency.
  always @(posedge clock) mem_q <= 32'hA500_0000 + {18'd0, mem_address[AW+1:2]};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic ready_for(input int m, input int c);
    case (m)
      0:       return 1'b1;
      1:       return (c % 3) == 0;
      default: return (c % 2) == 1;
    endcase
  endfunction

  function automatic logic busy_for(input int m, input int c);
    case (m)
      1:       return c < 19;
      2:       return (c >= 3) && (c <= 7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_dump(input vec_t v, input string tag);
    int          k, cyc, last_xfer, dones, extra, occ;
    bit          pstall;
    logic [31:0] pd;
    logic [13:0] pa, exp_a, last_a, issued;
    k = 0; cyc = 0; last_xfer = -1; dones = 0; extra = 0;
    pstall = 1'b0; pd = '0; pa = '0; last_a = '0;
    @(negedge clock);
    start = 1'b1; base_addr = v.base; word_count = v.cnt;
    mem_init_busy = (v.bmode == 1); out_ready = 1'b1;
    @(negedge clock);
    while (dones == 0 && cyc < 400) begin
      if (cyc == 0) chk({tag, ":busy_after_start"}, 64'(busy), 64'(v.cnt != 15'd0));
      start = v.restart && (cyc == 0);
      if (start) begin
        base_addr  = 14'h0300;
        word_count = 15'd2;
      end
      if (done) begin
        dones++;
        chk({tag, ":done_after_last"}, 64'(cyc), 64'(last_xfer + 1));
        chk({tag, ":words_delivered"}, 64'(k), 64'(v.cnt));
      end
      if (pstall) begin
        chk({tag, ":stall_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ":stall_addr"}, 64'(out_addr), 64'(pa));
        chk({tag, ":stall_data"}, 64'(out_data), 64'(pd));
      end
      if (v.bmode == 1 && cyc < 20) begin
        chk({tag, ":init_busy_addr"}, 64'(mem_address), 64'({v.base, 2'b00}));
        chk({tag, ":init_busy_valid"}, 64'(out_valid), 64'd0);
      end
      issued = mem_address[15:2] - v.base;
      occ = int'(issued) - k;
      chk({tag, ":occupancy"}, 64'((occ >= 0) && (occ <= 2) && (int'(issued) <= int'(v.cnt))), 64'd1);
      mem_init_busy = busy_for(v.bmode, cyc);
      out_ready     = ready_for(v.rmode, cyc);
      if (out_valid && out_ready) begin
        if (k >= int'(v.cnt)) begin
          extra++;
        end else begin
          exp_a = v.base + k[13:0];
          chk({tag, ":out_addr"}, 64'(out_addr), 64'(exp_a));
          chk({tag, ":out_data"}, 64'(out_data), 64'(32'hA500_0000 + {18'd0, exp_a}));
          if (v.rmode == 0 && v.bmode == 0 && k > 0)
            chk({tag, ":consecutive"}, 64'(cyc), 64'(last_xfer + 1));
        end
        last_a = out_addr; last_xfer = cyc; k++;
      end
      pstall = out_valid && !out_ready;
      pa = out_addr; pd = out_data;
      @(negedge clock);
      cyc++;
    end
    chk({tag, ":done_seen"}, 64'(dones), 64'd1);
    chk({tag, ":extra_words"}, 64'(extra), 64'd0);
    if (v.cnt != 15'd0) chk({tag, ":last_addr"}, 64'(last_a), 64'(v.exp_last));
    chk({tag, ":done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, ":busy_clear"}, 64'(busy), 64'd0);
    chk({tag, ":valid_clear"}, 64'(out_valid), 64'd0);
    chk({tag, ":wren"}, 64'(mem_wren), 64'd0);
    mem_init_busy = 1'b0;
  endtask

  initial begin
    int   k, guard, bad;
    vec_t v_after;

    vecs[0] = '{14'h0010, 15'd4, 0, 0, 1'b0, 14'h0013};
    vecs[1] = '{14'h3FFE, 15'd3, 0, 0, 1'b0, 14'h0000};
    vecs[2] = '{14'h0020, 15'd8, 1, 0, 1'b0, 14'h0027};
    vecs[3] = '{14'h0040, 15'd5, 0, 1, 1'b0, 14'h0044};
    vecs[4] = '{14'h0050, 15'd6, 0, 2, 1'b0, 14'h0055};
    vecs[5] = '{14'h0100, 15'd0, 0, 0, 1'b0, 14'h0000};
    vecs[6] = '{14'h3FFF, 15'd2, 2, 2, 1'b0, 14'h0000};
    vecs[7] = '{14'h0200, 15'd4, 0, 0, 1'b1, 14'h0203};

    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    mem_init_busy = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset:out_valid", 64'(out_valid), 64'd0);
    chk("reset:busy", 64'(busy), 64'd0);
    chk("reset:done", 64'(done), 64'd0);
    chk("reset:mem_address", 64'(mem_address), 64'd0);
    chk("reset:wren", 64'(mem_wren), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 6-word dump, right after word 2 is taken.
    @(negedge clock);
    start = 1'b1; base_addr = 14'h0060; word_count = 15'd6; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 2 && guard < 50) begin
      if (out_valid && out_ready) k++;
      guard++;
      if (k < 2) @(negedge clock);
    end
    chk("midrst:reached_word2", 64'(k), 64'd2);
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:busy", 64'(busy), 64'd0);
    chk("midrst:done", 64'(done), 64'd0);
    chk("midrst:mem_address", 64'(mem_address), 64'd0);
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (done || out_valid || busy) bad++;
    end
    chk("midrst:quiet_after", 64'(bad), 64'd0);

    v_after = '{14'h0070, 15'd6, 0, 0, 1'b0, 14'h0075};
    run_dump(v_after, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter AW, default 14, meaning word-address width; byte address width is AW+2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning output buffer entries; only the value 2 is supported.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port start  input  1  one-cycle dump request.
REQ-006 SHALL have port base_addr  input  AW  first word address, latched on an accepted start.
REQ-007 SHALL have port word_count  input  AW+1  number of words to dump, latched on an accepted start.
REQ-008 SHALL have port mem_init_busy  input  1  memory initializer active; reads are forbidden while it is 1.
REQ-009 SHALL have port mem_address  output  AW+2  byte address to memory, equal to {word_ptr, 2'b00}.
REQ-010 SHALL have port mem_wren  output  1  memory write enable, constant 0.
REQ-011 SHALL have port mem_q  input  32  memory read data, valid one cycle after the address is presented.
REQ-012 SHALL have port out_data  output  32  dumped word.
REQ-013 SHALL have port out_addr  output  AW  word address of out_data.
REQ-014 SHALL have port out_valid  output  1  out_data and out_addr are valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the word; transfer occurs when out_valid and out_ready are both 1.
REQ-016 SHALL have port busy  output  1  dump in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL use FSM states IDLE, RUN and FINISH.
REQ-019 SHALL accept start only in IDLE; start in RUN or FINISH SHALL be ignored.
REQ-020 On an accepted start with word_count=0, SHALL go IDLE->FINISH, pulse done in the next cycle, and issue no reads.
REQ-021 On an accepted start with word_count>0, SHALL go IDLE->RUN, with busy=1 from the next cycle.
REQ-022 In RUN, SHALL issue a read in a cycle only when mem_init_busy=0, issued<count and (fifo_cnt + inflight - pop) < 2, where pop = out_valid & out_ready.
REQ-023 An issued read in cycle t SHALL drive mem_address for word (base+issued) mod 2^AW in cycle t and capture mem_q into the FIFO at the end of t+1, tagged with that word address.
REQ-024 Word addresses SHALL wrap modulo 2^AW: base=2^AW-1 is followed by word 0.
REQ-025 out_valid SHALL be 1 exactly when the FIFO is non-empty; out_data and out_addr SHALL be the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Words SHALL be delivered in ascending address order with none dropped or duplicated; with out_ready held at 1, sustained throughput SHALL be 1 word per cycle.
REQ-027 When mem_init_busy rises during RUN, new issues SHALL pause, an in-flight read SHALL still be captured, and issuing SHALL resume after mem_init_busy falls.
REQ-028 A simultaneous FIFO push and pop SHALL leave fifo_cnt unchanged.
REQ-029 After the handshake of word number count, SHALL go RUN->FINISH; busy=0 and done=1 for exactly one cycle, then IDLE.
REQ-030 mem_wren SHALL be 0 in every cycle.

Reset
REQ-031 While rst=0 at a clock edge, SHALL enter IDLE, flush the FIFO, and clear inflight and counters, with out_valid=0, busy=0, done=0 and mem_address=0 from the next cycle.
REQ-032 A reset mid-dump SHALL abort the dump, emit no done pulse and discard pending words; the next start after rst=1 SHALL be accepted normally.

Verification
REQ-033 Memory word i preloaded with 0xA5000000+i; start, base=0x10, count=4, out_ready=1 -> out_addr 0x10..0x13 in consecutive cycles with data 0xA5000010..0xA5000013, then done one cycle after the last transfer.
REQ-034 base=0x3FFE, count=3 -> out_addr sequence 0x3FFE, 0x3FFF, 0x0000; mem_address sequence 0xFFF8, 0xFFFC, 0x0000.
REQ-035 count=8, out_ready toggling 1,0,0,1,... -> all 8 words in order, outputs stable during stalls, no issue while fifo_cnt+inflight=2.
REQ-036 mem_init_busy=1 for 20 cycles after start -> mem_address constant, no reads for 20 cycles, then a correct dump; mem_init_busy pulsed mid-dump -> no loss or duplicate.
REQ-037 count=0 -> done one cycle after start, out_valid never 1; start during RUN -> ignored, original dump completes.
REQ-038 rst=0 for one cycle after word 2 of 6 -> out_valid=0 and busy=0 next cycle, no done; a new start dumps correctly.
